// File: rtl/cache_system_assoc.sv
// cache_system_assoc: N-way set-associative, write-back, write-allocate data
// cache with per-set round-robin replacement and saturating hit/miss counters.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   Addr, WD, WE, RE    core access (byte address, write data, write, read)
//   RD, Mem_Stall       read data (0 unless a read completes), core stall
//   mem_req, mem_we     memory beat request; 1 = write-back beat, 0 = fill beat
//   mem_addr, mem_wdata byte address / write-back data of the current beat
//   mem_rdata, mem_ack  fill data, beat complete (one word per ack)
//   hit_count           first-lookup hits, saturating
//   miss_count          misses, saturating
module cache_system_assoc #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 16,
  parameter int WAYS           = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  input  logic              RE,
  output logic [DATA_W-1:0] RD,
  output logic              Mem_Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int BO_W  = $clog2(DATA_W / 8);
  localparam int WI_W  = $clog2(WORDS_PER_LINE);
  localparam int SI_W  = $clog2(SETS);
  localparam int TAG_W = ADDR_W - BO_W - WI_W - SI_W;
  // Field widths clamped to 1 so degenerate geometries still have a signal.
  localparam int WI_B  = (WI_W > 0) ? WI_W : 1;
  localparam int SI_B  = (SI_W > 0) ? SI_W : 1;
  localparam int WY_B  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t            state_q;
  logic [WI_B-1:0]   beat_q;
  logic [WY_B-1:0]   victim_q;
  logic              fill_done_q;

  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic [WY_B-1:0]   ptr_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS_PER_LINE];

  logic [WI_B-1:0]   word_idx;
  logic [SI_B-1:0]   set_idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WY_B-1:0]   hit_way;
  logic [WY_B-1:0]   victim;
  logic              hit_idle;
  logic              miss_idle;
  logic              last_beat;
  logic [WI_B-1:0]   next_beat;
  logic [WY_B-1:0]   ptr_next;

  // Masking instead of part-selects keeps zero-width fields legal.
  assign word_idx = WI_B'((Addr >> BO_W) & ADDR_W'(WORDS_PER_LINE - 1));
  assign set_idx  = SI_B'((Addr >> (BO_W + WI_W)) & ADDR_W'(SETS - 1));
  assign tag      = TAG_W'(Addr >> (BO_W + WI_W + SI_W));

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = ptr_q[set_idx];
    // Descending scan: the last match written is the lowest-numbered way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][set_idx] && (tag_q[w][set_idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WY_B'(w);
      end
      if (!valid_q[w][set_idx]) victim = WY_B'(w);
    end
  end

  assign hit_idle  = (state_q == IDLE) && (WE || RE) && hit;
  assign miss_idle = (state_q == IDLE) && (WE || RE) && !hit;
  assign Mem_Stall = (state_q != IDLE) || miss_idle;
  // A simultaneous WE and RE is a write, so RD stays 0 for it.
  assign RD        = (hit_idle && !WE) ? data_q[hit_way][set_idx][word_idx] : '0;

  assign last_beat = (beat_q == WI_B'(WORDS_PER_LINE - 1));
  assign next_beat = beat_q + 1'b1;
  assign ptr_next  = (ptr_q[set_idx] == WY_B'(WAYS - 1)) ? '0 : ptr_q[set_idx] + 1'b1;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                                  input logic [SI_B-1:0]  s,
                                                  input logic [WI_B-1:0]  b);
    return (ADDR_W'(t) << (BO_W + WI_W + SI_W)) |
           (ADDR_W'(s) << (BO_W + WI_W)) |
           (ADDR_W'(b) << BO_W);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      victim_q    <= '0;
      fill_done_q <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit_idle) begin
            if (WE) dirty_q[hit_way][set_idx] <= 1'b1;
            // The re-lookup right after a fill completes a miss, not a hit.
            if (!fill_done_q && (hit_count != '1)) hit_count <= hit_count + 32'd1;
          end else if (miss_idle) begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
            victim_q <= victim;
            beat_q   <= '0;
            mem_req  <= 1'b1;
            if (valid_q[victim][set_idx] && dirty_q[victim][set_idx]) begin
              state_q   <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= beat_addr(tag_q[victim][set_idx], set_idx, '0);
              mem_wdata <= data_q[victim][set_idx][0];
            end else begin
              state_q  <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= beat_addr(tag, set_idx, '0);
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (last_beat) begin
              dirty_q[victim_q][set_idx] <= 1'b0;
              state_q   <= FILL;
              beat_q    <= '0;
              mem_we    <= 1'b0;
              mem_addr  <= beat_addr(tag, set_idx, '0);
              mem_wdata <= '0;
            end else begin
              beat_q    <= next_beat;
              mem_addr  <= beat_addr(tag_q[victim_q][set_idx], set_idx, next_beat);
              mem_wdata <= data_q[victim_q][set_idx][next_beat];
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (last_beat) begin
              valid_q[victim_q][set_idx] <= 1'b1;
              dirty_q[victim_q][set_idx] <= 1'b0;
              ptr_q[set_idx] <= ptr_next;
              state_q     <= IDLE;
              beat_q      <= '0;
              mem_req     <= 1'b0;
              fill_done_q <= 1'b1;
            end else begin
              beat_q   <= next_beat;
              mem_addr <= beat_addr(tag, set_idx, next_beat);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (hit_idle && WE) data_q[hit_way][set_idx][word_idx] <= WD;
      if ((state_q == FILL) && mem_ack) begin
        data_q[victim_q][set_idx][beat_q] <= mem_rdata;
        if (last_beat) tag_q[victim_q][set_idx] <= tag;
      end
    end
  end

endmodule

// File: tb/tb_cache_system_assoc.sv
module tb_cache_system_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Addr, WD, RD;
  logic        WE, RE, Mem_Stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  cache_system_assoc #(
    .ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(4), .SETS(16), .WAYS(2)
  ) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .WD(WD), .WE(WE), .RE(RE), .RD(RD),
    .Mem_Stall(Mem_Stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_beat_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] wb_mem [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          acks_total = 0;
  int          ack_gap = 0;

  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory: written-back words, else a per-line pattern (0x40 -> 0xA0+i).
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (wb_mem.exists(a)) return wb_mem[a];
    return 32'hA0 + {(a[31:4] ^ 28'h4), 4'h0} + {30'd0, a[3:2]};
  endfunction

  task automatic push_line(input logic we, input logic [31:0] base,
                           input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) exp_beat_q.push_back('{we, base + 32'(4 * i), d[i]});
  endtask

  // Memory responder: acks every (ack_gap+1)-th cycle of a request.
  initial begin
    int cnt;
    cnt = 0; mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        if (cnt >= ack_gap) begin
          mem_ack = 1'b1; cnt = 0;
          if (mem_we) wb_mem[mem_addr] = mem_wdata;
          else mem_rdata = mem_read(mem_addr);
        end else begin
          mem_ack = 1'b0; cnt++;
        end
      end else begin
        mem_ack = 1'b0; cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever a beat is acked or an access completes.
  initial begin
    beat_t e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_ack) begin
        acks_total++;
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected beat: got addr %h we %b, expected no beat", mem_addr, mem_we);
        end else begin
          e = exp_beat_q.pop_front();
          check("beat we", {31'd0, mem_we}, {31'd0, e.we});
          check("beat addr", mem_addr, e.addr);
          if (e.we) check("beat wdata", mem_wdata, e.wdata);
        end
      end
      if (mem_req === 1'b1 && prev_req && !prev_ack) begin
        check("hold addr", mem_addr, prev_addr);
        check("hold we", {31'd0, mem_we}, {31'd0, prev_we});
      end
      if (rst && (WE || RE) && Mem_Stall === 1'b0) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected completion: got RD %h, expected none", RD);
        end else begin
          r = exp_rd_q.pop_front();
          check("RD", RD, r);
        end
      end
      prev_req  = (mem_req === 1'b1);
      prev_ack  = mem_ack;
      prev_we   = mem_we;
      prev_addr = mem_addr;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic do_access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input int exp_stall, input string name);
    int st;
    st = 0;
    exp_rd_q.push_back(exp_rd);
    WE = w; RE = r; Addr = a; WD = d;
    forever begin
      @(negedge clk);
      if (Mem_Stall === 1'b0) break;
      st++;
      if (st > 200) break;
    end
    check($sformatf("%s stall cycles", name), 32'(st), 32'(exp_stall));
    @(posedge clk); #1;
    WE = 1'b0; RE = 1'b0;
  endtask

  task automatic check_counts(input string name, input logic [31:0] h, input logic [31:0] m, input int acks);
    check($sformatf("%s hit_count", name), hit_count, h);
    check($sformatf("%s miss_count", name), miss_count, m);
    check($sformatf("%s beats", name), 32'(acks_total), 32'(acks));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; WE = 1'b0; RE = 1'b0; Addr = '0; WD = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset RD", RD, 32'd0);
    check("reset Mem_Stall", {31'd0, Mem_Stall}, 32'd0);
    check("reset hit_count", hit_count, 32'd0);
    check("reset miss_count", miss_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Clean read miss on an empty set.
    push_line(1'b0, 32'h40, 0, 0, 0, 0);
    do_access(1'b0, 1'b1, 32'h40, 32'h0, 32'hA0, 5, "read miss 0x40");
    check_counts("after read miss", 32'd0, 32'd1, 4);

    // Write hit then read hit: no memory traffic.
    do_access(1'b1, 1'b0, 32'h44, 32'hDEADBEEF, 32'h0, 0, "write hit 0x44");
    do_access(1'b0, 1'b1, 32'h44, 32'h0, 32'hDEADBEEF, 0, "read hit 0x44");
    check_counts("after hits", 32'd2, 32'd1, 4);

    // Same set, second tag fills the free way; third tag evicts dirty 0x40.
    push_line(1'b0, 32'h440, 0, 0, 0, 0);
    do_access(1'b0, 1'b1, 32'h440, 32'h0, 32'h4A0, 5, "read miss 0x440");
    push_line(1'b1, 32'h40, 32'hA0, 32'hDEADBEEF, 32'hA2, 32'hA3);
    push_line(1'b0, 32'h840, 0, 0, 0, 0);
    do_access(1'b0, 1'b1, 32'h848, 32'h0, 32'h8A2, 9, "dirty miss 0x848");
    check_counts("after eviction", 32'd2, 32'd3, 16);

    // Slow memory: refetch 0x40 (evicts clean 0x440), sees written-back word.
    ack_gap = 2;
    push_line(1'b0, 32'h40, 0, 0, 0, 0);
    do_access(1'b0, 1'b1, 32'h44, 32'h0, 32'hDEADBEEF, 13, "slow miss 0x44");
    ack_gap = 0;
    check_counts("after slow miss", 32'd2, 32'd4, 20);

    do_access(1'b1, 1'b0, 32'h4C, 32'h12345678, 32'h0, 0, "write hit 0x4C");
    do_access(1'b0, 1'b1, 32'h840, 32'h0, 32'h8A0, 0, "read hit 0x840");
    do_access(1'b0, 1'b1, 32'h4C, 32'h0, 32'h12345678, 0, "read hit 0x4C");

    // WE and RE together behave as a write with RD = 0.
    do_access(1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 32'h0, 0, "we+re 0x48");
    do_access(1'b0, 1'b1, 32'h48, 32'h0, 32'hCAFEF00D, 0, "read back 0x48");
    check_counts("after we+re", 32'd7, 32'd4, 20);

    // Reset after two fill beats of 0x80; the third beat's ack coincides with reset.
    push_line(1'b0, 32'h80, 0, 0, 0, 0);
    void'(exp_beat_q.pop_back());
    RE = 1'b1; Addr = 32'h80;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; RE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid-fill reset mem_req", {31'd0, mem_req}, 32'd0);
    check_counts("mid-fill reset", 32'd0, 32'd0, 23);
    @(posedge clk); #1;
    rst = 1'b1;
    push_line(1'b0, 32'h80, 0, 0, 0, 0);
    do_access(1'b0, 1'b1, 32'h80, 32'h0, 32'h160, 5, "re-read 0x80");
    check_counts("after re-read", 32'd0, 32'd1, 27);

    repeat (3) @(posedge clk);
    check("beats left", 32'(exp_beat_q.size()), 32'd0);
    check("reads left", 32'(exp_rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_system_assoc.md
# cache_system_assoc

Parametrised successor to the direct-mapped cache subsystem: an N-way set-associative, write-back, write-allocate data cache with per-set round-robin replacement. It sits between the RISC-V core's data port and an external word-wide memory with a req/ack handshake. The core stalls through `Mem_Stall` until the access completes. It also exposes saturating hit/miss counters for performance tuning.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width; a multiple of 8
- `WORDS_PER_LINE`, 4, words per cache line; a power of 2, ≥1
- `SETS`, 16, number of sets; a power of 2, ≥1
- `WAYS`, 2, associativity; 1, 2 or 4

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous and active-low
- `Addr`  in  ADDR_W  byte address; word-aligned, byte-offset bits ignored
- `WD`  in  DATA_W  write data
- `WE`  in  1  write request
- `RE`  in  1  read request
- `RD`  out  DATA_W  read data; valid when `RE && !Mem_Stall`, otherwise 0
- `Mem_Stall`  out  1  core must hold `Addr`/`WD`/`WE`/`RE` while high
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  1 = write-back beat, 0 = fill beat
- `mem_addr`  out  ADDR_W  byte address of the current beat's word
- `mem_wdata`  out  DATA_W  write-back data
- `mem_rdata`  in  DATA_W  fill data; sampled when `mem_ack` is high
- `mem_ack`  in  1  beat complete; one word per ack
- `hit_count`  out  32  accesses that hit on first lookup; saturating
- `miss_count`  out  32  misses; saturating

## Operation
- **Address split, from the LSB:**
  - byte offset: log2(DATA_W/8) bits
  - word index: log2(WORDS_PER_LINE) bits
  - set index: log2(SETS) bits
  - tag: the remaining bits
- **Per-way state per set:** valid, dirty, tag, data line.
- **Per-set state:** a round-robin victim pointer of log2(WAYS) bits.
- **Access:** `WE || RE`. If both are high, the access is treated as a write.
- **FSM states:** IDLE, WRITEBACK, FILL.
- **IDLE:**
  - Tags are compared combinationally across all ways.
  - Read hit: `RD` = the hit word.
  - Write hit: the word is written at the clock edge and dirty is set.
  - Miss: `Mem_Stall`=1 in the same cycle.
  - Victim selection: the lowest-numbered invalid way; otherwise the way at the victim pointer.
  - Next state on a miss: WRITEBACK if the victim is valid and dirty, else FILL.
- **WRITEBACK:**
  - Issues WORDS_PER_LINE beats with `mem_we`=1.
  - `mem_addr` = {victim tag, set index, beat index, 0s}.
  - `mem_wdata` = the victim word for the current beat.
  - Advances one beat per `mem_ack`.
  - After the last ack, goes to FILL and clears dirty.
- **FILL:**
  - Issues WORDS_PER_LINE beats with `mem_we`=0 and the requested tag.
  - Each acked `mem_rdata` is written into the victim way at the beat index.
  - After the last ack: set valid, load the tag, clear dirty, advance the set's victim pointer (mod WAYS), return to IDLE.
- **Miss completion:** the re-lookup in IDLE hits and completes the access. A write then merges `WD` and sets dirty.
- **Counters:**
  - `hit_count` increments on an IDLE hit only when the previous cycle was not a FILL completion, so the re-lookup after a miss is not counted as a hit.
  - `miss_count` increments once per IDLE miss detection.
  - Both saturate at 2^32−1.
- **`mem_req`:** high for the whole of WRITEBACK and FILL, including the cycle of each ack; low in IDLE.
- **Reset (`rst`=0 at an edge):**
  - clears all valid, dirty and victim pointers, and both counters; FSM goes to IDLE.
  - Registered outputs `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `RD`=0, and `Mem_Stall`=0 whenever no access is presented.
  - A reset mid-burst aborts the burst; `mem_req` is low in the next cycle and the partially filled line stays invalid.
  - Tag and data arrays need not be reset.

## Timing
- Hit: zero extra cycles. `Mem_Stall`=0 and `RD` are valid combinationally in the access cycle.
- Clean miss with `mem_ack` every cycle: `Mem_Stall` is high for WORDS_PER_LINE+1 cycles; the access completes in the following IDLE cycle.
- Dirty miss: `Mem_Stall` is high for 2·WORDS_PER_LINE+1 cycles with ack every cycle.
- Beat ordering: beats are issued in ascending word order, starting at word 0.
- Memory-side rules:
  - `mem_addr`, `mem_we` and `mem_wdata` are stable from `mem_req` rise until `mem_ack`.
  - Ack-to-next-beat: the next beat's address is presented in the cycle after the ack.
  - Ack latency is unbounded; the FSM waits indefinitely.
  - `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- **Reset, then read miss.** Reset, then `RE`, `Addr`=0x40 with memory returning word i = 0xA0+i. Required: 4 fill beats at 0x40, 0x44, 0x48, 0x4C; `Mem_Stall` high 5 cycles; `RD`=0xA0; `miss_count`=1, `hit_count`=0.
- **Write hit then read.** Write 0xDEADBEEF to 0x44, then read 0x44. Required: no memory traffic; `RD`=0xDEADBEEF; `hit_count`=2.
- **Dirty eviction.** With WAYS=2 and SETS=16, touch 0x40, 0x440 and 0x840 (same set, three tags). Required: the third access writes back line 0x40 first (4 beats, `mem_we`=1, word 1 = 0xDEADBEEF), then fills 0x840.
- **Slow memory.** `mem_ack` every 3rd cycle. Required: `mem_addr`/`mem_we` are stable while each beat waits; correct data is returned.
- **Reset mid-fill.** Pull `rst` low after beat 2 of a fill. Required: `mem_req`=0 next cycle; a subsequent read of the same address misses again.
- **Simultaneous `WE` and `RE`.** Required: treated as a write; `RD`=0.
